// File: rtl/ysyx_23060072_fetch_pc.sv
// ============================================================================
// ysyx_23060072_fetch_pc
//
// PC generation plus the IF/ID pipeline register for the rv32e pipeline.
// Each cycle the current PC is presented to the instruction ROM. The ROM
// word returned in the same cycle is captured into IF/ID on the next edge,
// together with its PC.
//
// Per-edge priority: rst > redirect > stall > advance.
//   - Redirect from EX (taken branch / jal / jalr): PC jumps to the word-aligned
//     target and IF/ID is flushed to a NOP bubble. A redirect wins over a
//     simultaneous stall, so a wrong-path slot is never held.
//   - Stall from the hazard unit: PC and IF/ID hold.
//   - Advance: IF/ID <= {pc, rom word}, PC <= PC + 4 (32-bit wrap).
//
// Optional build macro: FETCH_PERF_CNT_EN
//   When defined, three saturating performance counters (fetch/stall/flush)
//   and their output ports are added. When undefined they do not exist.
//
// Parameters:
//   RESET_PC  PC loaded on reset
//   NOP_INST  bubble word written to IF/ID on reset/flush (addi x0,x0,0)
//   CNT_W     perf counter width (only meaningful with FETCH_PERF_CNT_EN)
//
// Ports:
//   clk               in   1      clock, rising edge
//   rst               in   1      synchronous reset, active-high
//   stall_i           in   1      hazard unit: hold PC and IF/ID
//   redirect_valid_i  in   1      EX stage redirect request
//   redirect_pc_i     in   32     redirect target
//   instr_addr_o      out  32     fetch address to ROM (current PC)
//   inst_rdata_i      in   32     ROM word for instr_addr_o, same cycle
//   id_valid_o        out  1      IF/ID holds a real instruction
//   id_pc_o           out  32     PC of the instruction in IF/ID
//   id_inst_o         out  32     instruction in IF/ID
//   fetch_cnt_o       out  CNT_W  [FETCH_PERF_CNT_EN] accepted instructions
//   stall_cnt_o       out  CNT_W  [FETCH_PERF_CNT_EN] stall cycles
//   flush_cnt_o       out  CNT_W  [FETCH_PERF_CNT_EN] redirect cycles
// ============================================================================
module ysyx_23060072_fetch_pc #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              redirect_valid_i,
    input  logic [31:0]       redirect_pc_i,
    output logic [31:0]       instr_addr_o,
    input  logic [31:0]       inst_rdata_i,
    output logic              id_valid_o,
    output logic [31:0]       id_pc_o,
    output logic [31:0]       id_inst_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  fetch_cnt_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_id_valid;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_inst;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_pc;
    logic        w_advance;
    logic        w_stall_hold;

    // Modular add: 32'hFFFF_FFFC + 4 wraps to 0.
    assign w_pc_plus4    = r_pc + 32'd4;
    // Targets are forced word-aligned; the low two bits are dropped.
    assign w_redirect_pc = redirect_pc_i & ~32'h3;

    assign w_advance    = !redirect_valid_i && !stall_i;
    assign w_stall_hold = !redirect_valid_i &&  stall_i;

    // ------------------------------------------------------------------------
    // PC / IF-ID state machine. BOOT only separates the release cycle from
    // normal running; it honours redirect and stall exactly like RUN, and the
    // earliest valid IF/ID entry appears one edge after reset release.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_PC;
            r_id_valid <= 1'b0;
            r_id_pc    <= 32'h0;
            r_id_inst  <= NOP_INST;
        end else begin
            case (r_state)
                S_BOOT, S_RUN: begin
                    if (redirect_valid_i) begin
                        r_pc       <= w_redirect_pc;
                        r_id_valid <= 1'b0;
                        r_id_pc    <= 32'h0;
                        r_id_inst  <= NOP_INST;
                    end else if (!stall_i) begin
                        r_pc       <= w_pc_plus4;
                        r_id_valid <= 1'b1;
                        r_id_pc    <= r_pc;
                        r_id_inst  <= inst_rdata_i;
                    end
                    r_state <= S_RUN;
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    assign instr_addr_o = r_pc;
    assign id_valid_o   = r_id_valid;
    assign id_pc_o      = r_id_pc;
    assign id_inst_o    = r_id_inst;

`ifdef FETCH_PERF_CNT_EN
    // ------------------------------------------------------------------------
    // Saturating performance counters, indexed 0=fetch, 1=stall, 2=flush.
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] r_cnt [3];
    logic [2:0]       w_cnt_inc;

    assign w_cnt_inc[0] = w_advance;
    assign w_cnt_inc[1] = w_stall_hold;
    assign w_cnt_inc[2] = redirect_valid_i;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt[gi] <= '0;
                end else if (w_cnt_inc[gi] && (r_cnt[gi] != {CNT_W{1'b1}})) begin
                    r_cnt[gi] <= r_cnt[gi] + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    endgenerate

    assign fetch_cnt_o = r_cnt[0];
    assign stall_cnt_o = r_cnt[1];
    assign flush_cnt_o = r_cnt[2];
`else
    // Counter events are only consumed when the counters are built.
    logic w_unused_cnt;
    assign w_unused_cnt = w_advance ^ w_stall_hold;

    // A counter width below 1 is meaningless even when counters are absent.
    generate
        if (CNT_W < 1) begin : g_cnt_w_invalid
            logic w_cnt_w_invalid;
            assign w_cnt_w_invalid = 1'b1;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_ysyx_23060072_fetch_pc.sv
module tb_ysyx_23060072_fetch_pc;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] instr_addr_o;
    logic [31:0] inst_rdata_i;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_o, stall_cnt_o, flush_cnt_o;
    logic [31:0] s_addr, s_pc, s_inst;
    logic        s_valid;
    logic [3:0]  s_fetch, s_stall, s_flush;
`endif

    int n_cmp;
    int n_bad;

    // ROM model: distinct, address-dependent word per location.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    assign inst_rdata_i = rom(instr_addr_o);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ysyx_23060072_fetch_pc dut (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .instr_addr_o     (instr_addr_o),
        .inst_rdata_i     (inst_rdata_i),
        .id_valid_o       (id_valid_o),
        .id_pc_o          (id_pc_o),
        .id_inst_o        (id_inst_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt_o      (fetch_cnt_o),
        .stall_cnt_o      (stall_cnt_o),
        .flush_cnt_o      (flush_cnt_o)
`endif
    );

`ifdef FETCH_PERF_CNT_EN
    ysyx_23060072_fetch_pc #(.CNT_W(4)) dut_small (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .instr_addr_o     (s_addr),
        .inst_rdata_i     (rom(s_addr)),
        .id_valid_o       (s_valid),
        .id_pc_o          (s_pc),
        .id_inst_o        (s_inst),
        .fetch_cnt_o      (s_fetch),
        .stall_cnt_o      (s_stall),
        .flush_cnt_o      (s_flush)
    );
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
        $display("check %-14s observed %h expected %h", tag, got, exp);
    endtask

    // One clock: inputs change and outputs are sampled 1 time unit after posedge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_id(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] inst, input logic [31:0] addr);
        check({tag, ".valid"}, {31'h0, id_valid_o}, {31'h0, v});
        check({tag, ".pc"},    id_pc_o,     pc);
        check({tag, ".inst"},  id_inst_o,   inst);
        check({tag, ".addr"},  instr_addr_o, addr);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        stall_i = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i = 32'h0;

        // 1. Reset 3 cycles then free-run.
        repeat (3) step();
        check_id("reset", 1'b0, 32'h0, 32'h0000_0013, 32'h8000_0000);
        rst = 1'b0;
        #1;
        check_id("release", 1'b0, 32'h0, 32'h0000_0013, 32'h8000_0000);
        step();
        check_id("adv0", 1'b1, 32'h8000_0000, rom(32'h8000_0000), 32'h8000_0004);
        step();
        check_id("adv1", 1'b1, 32'h8000_0004, rom(32'h8000_0004), 32'h8000_0008);

        // 2. Stall for two cycles at pc 8000_0008.
        stall_i = 1'b1;
        step();
        check_id("stall0", 1'b1, 32'h8000_0004, rom(32'h8000_0004), 32'h8000_0008);
        step();
        check_id("stall1", 1'b1, 32'h8000_0004, rom(32'h8000_0004), 32'h8000_0008);
        stall_i = 1'b0;
        step();
        check_id("resume", 1'b1, 32'h8000_0008, rom(32'h8000_0008), 32'h8000_000C);

        // 3. Redirect to unaligned target; low bits dropped, one bubble.
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'h8000_0043;
        step();
        check_id("redir", 1'b0, 32'h0, 32'h0000_0013, 32'h8000_0040);
        redirect_valid_i = 1'b0;
        step();
        check_id("redir_tgt", 1'b1, 32'h8000_0040, rom(32'h8000_0040), 32'h8000_0044);

        // 4. Redirect together with stall: redirect wins.
        redirect_valid_i = 1'b1;
        stall_i = 1'b1;
        redirect_pc_i = 32'h8000_0100;
        step();
        check_id("redir_stall", 1'b0, 32'h0, 32'h0000_0013, 32'h8000_0100);
        redirect_valid_i = 1'b0;
        step();
        check_id("bubble_hold", 1'b0, 32'h0, 32'h0000_0013, 32'h8000_0100);
        stall_i = 1'b0;
        step();
        check_id("after_bubble", 1'b1, 32'h8000_0100, rom(32'h8000_0100), 32'h8000_0104);
        repeat (5) step();
        check_id("run5", 1'b1, 32'h8000_0114, rom(32'h8000_0114), 32'h8000_0118);
`ifdef FETCH_PERF_CNT_EN
        // 10 advances, 3 stalls, 2 redirects so far.
        check("fetch_cnt", fetch_cnt_o, 32'd10);
        check("stall_cnt", stall_cnt_o, 32'd3);
        check("flush_cnt", flush_cnt_o, 32'd2);
        check("s_fetch", {28'h0, s_fetch}, 32'hA);
`endif
        repeat (8) step();
        check("run8.addr", instr_addr_o, 32'h8000_0138);
`ifdef FETCH_PERF_CNT_EN
        check("fetch_cnt18", fetch_cnt_o, 32'd18);
        check("s_fetch_sat", {28'h0, s_fetch}, 32'hF);
        check("s_stall", {28'h0, s_stall}, 32'h3);
`endif

        // 5. Wrap-around from FFFF_FFFC.
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        step();
        check_id("to_top", 1'b0, 32'h0, 32'h0000_0013, 32'hFFFF_FFFC);
        redirect_valid_i = 1'b0;
        step();
        check_id("wrap", 1'b1, 32'hFFFF_FFFC, rom(32'hFFFF_FFFC), 32'h0000_0000);
        step();
        check_id("wrap1", 1'b1, 32'h0000_0000, rom(32'h0000_0000), 32'h0000_0004);

        // Reset while stalled (and a redirect pending): reset wins.
        stall_i = 1'b1;
        step();
        rst = 1'b1;
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'h1234_5678;
        step();
        check_id("mid_rst", 1'b0, 32'h0, 32'h0000_0013, 32'h8000_0000);
`ifdef FETCH_PERF_CNT_EN
        check("rst_fetch", fetch_cnt_o, 32'd0);
        check("rst_stall", stall_cnt_o, 32'd0);
        check("rst_flush", flush_cnt_o, 32'd0);
`endif
        rst = 1'b0;
        stall_i = 1'b0;
        redirect_valid_i = 1'b0;
        step();
        check_id("reboot", 1'b1, 32'h8000_0000, rom(32'h8000_0000), 32'h8000_0004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: observed no-finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
